// File: rtl/crossbar_pkg.sv
// Shared types and the round-robin pick helper for the crossbar arbitration stage.
// rr_pick is pure combinational; callers register its result.
package crossbar_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam int RR_MAX = 32;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching upward from (last+1) mod n, with wrap.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input int n, input int last);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !r.found && idx < RR_MAX && req[idx[4:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[7:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_output_arbiter.sv
// One output's round-robin arbiter: grants 1 cycle after a request, holds the grant
// until the granted master's last beat is accepted by the sink, then idles one cycle.
module rr_output_arbiter
  import crossbar_pkg::*;
#(
  parameter  int S_DATA_COUNT = 2,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_COUNT-1:0] req,
  input  logic [S_DATA_COUNT-1:0] valid,
  input  logic [S_DATA_COUNT-1:0] last,
  input  logic                    ready,
  output logic [T_ID___WIDTH-1:0] grant,
  output logic                    busy
);

  arb_state_t              state_q, state_d;
  logic [T_ID___WIDTH-1:0] grant_q, grant_d;
  logic [T_ID___WIDTH-1:0] last_q, last_d;
  rr_pick_t                pick;
  logic                    pick_unused;
  logic                    release_pkt;

  assign pick        = rr_pick(RR_MAX'(req), S_DATA_COUNT, int'(last_q));
  assign pick_unused = ^pick.idx;
  assign release_pkt = valid[grant_q] && last[grant_q] && ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick.found) begin
          state_d = ARB_BUSY;
          grant_d = pick.idx[T_ID___WIDTH-1:0];
        end
      end
      ARB_BUSY: begin
        // Release always lands in IDLE, so back-to-back packets see one bubble.
        if (release_pkt) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= T_ID___WIDTH'(S_DATA_COUNT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ARB_BUSY);

endmodule

// File: rtl/crossbar_arbiter_unit.sv
// Per-output arbitration for the stream crossbar: forms each output's request vector
// and runs one registered round-robin arbiter per output (request-to-grant 1 cycle).
module crossbar_arbiter_unit
  import crossbar_pkg::*;
#(
  parameter  int S_DATA_COUNT = 2,
  parameter  int M_DATA_COUNT = 3,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] grant_o,
  output logic [M_DATA_COUNT-1:0]              arbiter_ready_o
);

  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_out
    logic [S_DATA_COUNT-1:0] req;

    always_comb begin
      req = '0;
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        req[j] = s_valid_i[j] && (s_dest_i[j*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(i));
      end
    end

    rr_output_arbiter #(
      .S_DATA_COUNT(S_DATA_COUNT)
    ) u_arb (
      .clk  (clk_i),
      .rst  (rst_i),
      .req  (req),
      .valid(s_valid_i),
      .last (s_last_i),
      .ready(m_ready_i[i]),
      .grant(grant_o[i*T_ID___WIDTH +: T_ID___WIDTH]),
      .busy (arbiter_ready_o[i])
    );
  end

endmodule

// File: tb/tb_crossbar_arbiter_unit.sv
// Directed bench for crossbar_arbiter_unit with S=2, M=3; expected values hand-computed.
module tb_crossbar_arbiter_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_dest;
  logic [1:0] s_valid;
  logic [1:0] s_last;
  logic [2:0] m_ready;
  logic [2:0] grant;
  logic [2:0] arb_rdy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crossbar_arbiter_unit #(
    .S_DATA_COUNT(2),
    .M_DATA_COUNT(3)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_dest_i       (s_dest),
    .s_valid_i      (s_valid),
    .s_last_i       (s_last),
    .m_ready_i      (m_ready),
    .grant_o        (grant),
    .arbiter_ready_o(arb_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // grant bus packs {g2, g1, g0}, one bit per output since S=2
  task automatic chk(input string tag, input logic [2:0] rdy_exp, input logic [2:0] gnt_exp);
    n_vec++;
    assert (arb_rdy === rdy_exp)
    else begin
      n_err++;
      $error("FAIL %s arbiter_ready: got %b want %b", tag, arb_rdy, rdy_exp);
    end
    n_vec++;
    assert (grant === gnt_exp)
    else begin
      n_err++;
      $error("FAIL %s grant: got %b want %b", tag, grant, gnt_exp);
    end
  endtask

  task automatic drive(input logic [1:0] d1, input logic [1:0] d0, input logic [1:0] v,
                       input logic [1:0] l, input logic [2:0] r);
    s_dest  = {d1, d0};
    s_valid = v;
    s_last  = l;
    m_ready = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'd0, 2'd0, 2'b00, 2'b00, 3'b000);

    // reset held 3 cycles with random inputs
    for (int c = 0; c < 3; c++) begin
      s_dest  = 4'($urandom);
      s_valid = 2'($urandom);
      s_last  = 2'($urandom);
      m_ready = 3'($urandom);
      tick();
      chk("reset", 3'b000, 3'b000);
    end

    // round-robin on output 0 with 1-beat packets
    rst = 1'b0;
    drive(2'd0, 2'd0, 2'b11, 2'b00, 3'b000);
    tick(); chk("first_contest_m0", 3'b001, 3'b000);
    drive(2'd0, 2'd0, 2'b11, 2'b11, 3'b001);
    tick(); chk("rr_release0", 3'b000, 3'b000);
    tick(); chk("rr_grant1", 3'b001, 3'b001);
    tick(); chk("rr_release1", 3'b000, 3'b001);
    tick(); chk("rr_grant0", 3'b001, 3'b000);
    tick(); chk("rr_release0b", 3'b000, 3'b000);
    tick(); chk("rr_grant1b", 3'b001, 3'b001);

    // backpressure: last asserted, sink not ready for 4 cycles
    drive(2'd0, 2'd0, 2'b10, 2'b10, 3'b000);
    for (int c = 0; c < 4; c++) begin
      tick(); chk("bp_hold", 3'b001, 3'b001);
    end
    m_ready = 3'b001;
    tick(); chk("bp_release", 3'b000, 3'b001);
    drive(2'd0, 2'd0, 2'b00, 2'b00, 3'b000);
    tick(); chk("bp_idle", 3'b000, 3'b001);

    // single 3-beat packet master 1 -> output 2, with a valid gap
    drive(2'd2, 2'd0, 2'b10, 2'b00, 3'b100);
    tick(); chk("pkt_grant", 3'b100, 3'b101);
    tick(); chk("pkt_beat1", 3'b100, 3'b101);
    tick(); chk("pkt_beat2", 3'b100, 3'b101);
    s_valid = 2'b00;
    tick(); chk("pkt_gap", 3'b100, 3'b101);
    s_valid = 2'b10;
    s_last  = 2'b10;
    tick(); chk("pkt_release", 3'b000, 3'b101);
    drive(2'd0, 2'd0, 2'b00, 2'b00, 3'b000);
    tick(); chk("pkt_idle", 3'b000, 3'b101);

    // parallel outputs: m0 -> out1, m1 -> out2
    drive(2'd2, 2'd1, 2'b11, 2'b00, 3'b000);
    tick(); chk("par_grant", 3'b110, 3'b101);
    s_last  = 2'b11;
    m_ready = 3'b110;
    tick(); chk("par_release", 3'b000, 3'b101);

    // mid-packet reset: move out0 pointer to 0, then let master 1 hold out0
    drive(2'd0, 2'd0, 2'b11, 2'b11, 3'b001);
    tick(); chk("mr_grant0", 3'b001, 3'b100);
    tick(); chk("mr_release0", 3'b000, 3'b100);
    s_last = 2'b00;
    tick(); chk("mr_grant1", 3'b001, 3'b101);
    rst = 1'b1;
    tick(); chk("mr_reset", 3'b000, 3'b000);
    rst = 1'b0;
    tick(); chk("mr_after_m0", 3'b001, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
